// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, operand width and the small
// state enums used by the ALU sharing logic.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: one-hot grant from the eligible vector,
// pointer flips to the other requester after every grant.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] elig_i,
    input  ptr_e       ptr_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output ptr_e       ptr_next_o
);

    always_comb begin
        gnt_o      = 2'b00;
        ptr_next_o = ptr_i;
        unique case (elig_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (ptr_i == PTR_REQ1) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        if (upd_i && (gnt_o != 2'b00)) begin
            ptr_next_o = gnt_o[0] ? PTR_REQ1 : PTR_REQ0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between two requesters, capturing each result
// into a per-requester response slot drained over valid/ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    slot_e            slot0_q, slot0_d, slot1_q, slot1_d;
    ptr_e             ptr_q, ptr_d;
    logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic             zero0_q, zero0_d, zero1_q, zero1_d;
    logic [1:0]       elig;
    logic [1:0]       gnt;

    // A full slot can accept a new op only in the cycle it is drained
    always_comb begin
        elig    = 2'b00;
        elig[0] = req0_valid & ((slot0_q == SLOT_EMPTY) | resp0_ready) & ~reset;
        elig[1] = req1_valid & ((slot1_q == SLOT_EMPTY) | resp1_ready) & ~reset;
    end

    rr_arb2 u_arb (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .upd_i     (~reset),
        .gnt_o     (gnt),
        .ptr_next_o(ptr_d)
    );

    // AND-mux keeps the ALU inputs at zero when idle
    always_comb begin
        alu_a       = ({WIDTH{gnt[0]}} & req0_a)  | ({WIDTH{gnt[1]}} & req1_a);
        alu_b       = ({WIDTH{gnt[0]}} & req0_b)  | ({WIDTH{gnt[1]}} & req1_b);
        alu_control = ({3{gnt[0]}} & req0_op) | ({3{gnt[1]}} & req1_op);
    end

    always_comb begin
        slot0_d = slot0_q;
        res0_d  = res0_q;
        zero0_d = zero0_q;
        if (gnt[0]) begin
            slot0_d = SLOT_FULL;
            res0_d  = alu_result;
            zero0_d = alu_zero;
        end else if (resp0_ready) begin
            slot0_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        slot1_d = slot1_q;
        res1_d  = res1_q;
        zero1_d = zero1_q;
        if (gnt[1]) begin
            slot1_d = SLOT_FULL;
            res1_d  = alu_result;
            zero1_d = alu_zero;
        end else if (resp1_ready) begin
            slot1_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= SLOT_EMPTY;
            slot1_q <= SLOT_EMPTY;
            ptr_q   <= PTR_REQ0;
            res0_q  <= '0;
            res1_q  <= '0;
            zero0_q <= 1'b0;
            zero1_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            ptr_q   <= ptr_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            zero0_q <= zero0_d;
            zero1_q <= zero1_d;
        end
    end

    always_comb begin
        req0_ready   = gnt[0];
        req1_ready   = gnt[1];
        resp0_valid  = (slot0_q == SLOT_FULL);
        resp1_valid  = (slot1_q == SLOT_FULL);
        resp0_result = res0_q;
        resp1_result = res1_q;
        resp0_zero   = zero0_q;
        resp1_zero   = zero1_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter with a scoreboard
// per requester and a behavioural ALU beside the DUT.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int W = ALU_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [W-1:0] resp0_result, resp1_result;
    logic         resp0_zero, resp1_zero;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_control;
    logic         alu_zero;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [1:0] m_full;
    logic       m_ptr;
    logic [1:0] m_gnt = 2'b00;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_control, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_result(resp0_result),
        .resp0_zero  (resp0_zero),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_result(resp1_result),
        .resp1_zero  (resp1_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected grant from the arbitration rules, checked mid-cycle
    always @(negedge clk) begin : grant_model
        logic [1:0]   el;
        logic [1:0]   g;
        logic [W-1:0] ea, eb;
        logic [2:0]   eo;
        el[0] = !reset && req0_valid && (!m_full[0] || resp0_ready);
        el[1] = !reset && req1_valid && (!m_full[1] || resp1_ready);
        if (el == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
        else             g = el;
        ea = g[0] ? req0_a  : (g[1] ? req1_a  : '0);
        eb = g[0] ? req0_b  : (g[1] ? req1_b  : '0);
        eo = g[0] ? req0_op : (g[1] ? req1_op : 3'b000);
        chk1("req0_ready", req0_ready, g[0]);
        chk1("req1_ready", req1_ready, g[1]);
        chk1("resp0_valid", resp0_valid, m_full[0]);
        chk1("resp1_valid", resp1_valid, m_full[1]);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_control", {29'd0, alu_control}, {29'd0, eo});
        m_gnt <= g;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_full <= 2'b00;
            m_ptr  <= 1'b0;
            q0.delete();
            q1.delete();
        end else begin
            if (m_gnt[0]) q0.push_back('{ref_alu(req0_op, req0_a, req0_b),
                                         ref_alu(req0_op, req0_a, req0_b) == '0});
            if (m_gnt[1]) q1.push_back('{ref_alu(req1_op, req1_a, req1_b),
                                         ref_alu(req1_op, req1_a, req1_b) == '0});
            m_full[0] <= m_gnt[0] | (m_full[0] & ~resp0_ready);
            m_full[1] <= m_gnt[1] | (m_full[1] & ~resp1_ready);
            if (m_gnt != 2'b00) m_ptr <= m_gnt[1] ? 1'b0 : 1'b1;
        end
    end

    // Monitor: every drained response must match the oldest expected one
    always @(negedge clk) begin
        exp_t e;
        if (resp0_valid && resp0_ready) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp0_unexpected: got %0h expected none", resp0_result);
            end else begin
                e = q0.pop_front();
                chk("resp0_result", resp0_result, e.r);
                chk1("resp0_zero", resp0_zero, e.z);
            end
        end
        if (resp1_valid && resp1_ready) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp1_unexpected: got %0h expected none", resp1_result);
            end else begin
                e = q1.pop_front();
                chk("resp1_result", resp1_result, e.r);
                chk1("resp1_zero", resp1_zero, e.z);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op);
        req0_valid = v;
        req0_a     = a;
        req0_b     = b;
        req0_op    = op;
    endtask

    task automatic set1(input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op);
        req1_valid = v;
        req1_a     = a;
        req1_b     = b;
        req1_op    = op;
    endtask

    initial begin
        logic [1:0] seen [4];
        logic [1:0] want [4];
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        reset = 1'b1;
        m_full = 2'b00;
        m_ptr  = 1'b0;
        set0(1'b1, 32'd5, 32'd3, ALU_ADD);
        set1(1'b1, 32'd1, 32'd2, ALU_ADD);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_resp0_result", resp0_result, 32'd0);
        chk("rst_resp1_result", resp1_result, 32'd0);
        chk1("rst_resp0_zero", resp0_zero, 1'b0);
        chk1("rst_resp1_zero", resp1_zero, 1'b0);
        tick();

        // single ADD on requester 0
        reset = 1'b0;
        set1(1'b0, 0, 0, 3'b000);
        set0(1'b1, 32'd5, 32'd3, ALU_ADD);
        @(negedge clk);
        chk1("add_ready", req0_ready, 1'b1);
        tick();
        set0(1'b0, 0, 0, 3'b000);
        @(negedge clk);
        chk1("add_valid", resp0_valid, 1'b1);
        chk("add_result", resp0_result, 32'd8);
        chk1("add_zero", resp0_zero, 1'b0);
        tick();
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;

        // alternation from a fresh pointer
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set0(1'b1, 32'd7, 32'd7, ALU_SUB);
        set1(1'b1, 32'd2, 32'd9, ALU_SLT);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[i] = {req1_ready, req0_ready};
            tick();
        end
        for (int i = 0; i < 4; i++) chk("alt_grant", {30'd0, seen[i]}, {30'd0, want[i]});
        set0(1'b0, 0, 0, 3'b000);
        set1(1'b0, 0, 0, 3'b000);
        @(negedge clk);
        chk("sub_result", resp0_result, 32'd0);
        chk1("sub_zero", resp0_zero, 1'b1);
        chk("slt_result", resp1_result, 32'd1);
        tick();

        // requester 1 blocked by its full slot
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        set1(1'b1, 32'd1, 32'd1, ALU_ADD);
        tick();
        set1(1'b1, 32'd4, 32'd4, ALU_ADD);
        set0(1'b1, 32'd2, 32'd3, ALU_AND);
        resp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("blk_req1_ready", req1_ready, 1'b0);
            chk1("blk_req0_ready", req0_ready, 1'b1);
            tick();
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        chk1("refill_req1_ready", req1_ready, 1'b1);
        tick();
        set0(1'b0, 0, 0, 3'b000);
        set1(1'b0, 0, 0, 3'b000);
        tick();
        @(negedge clk);
        chk("refill_result", resp1_result, 32'd8);
        tick();
        resp1_ready = 1'b0;

        // streaming on requester 0
        resp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 32'(i * 10 + 1), 32'(i), ALU_ADD);
            @(negedge clk);
            chk1("stream_ready", req0_ready, 1'b1);
            tick();
        end
        set0(1'b0, 0, 0, 3'b000);
        tick();
        resp0_ready = 1'b0;

        // reset with both slots full and a grant pending
        set0(1'b1, 32'd100, 32'd23, ALU_ADD);
        set1(1'b1, 32'h0f0, 32'h00f, ALU_OR);
        repeat (2) tick();
        set0(1'b1, 32'd9, 32'd9, ALU_ADD);
        resp0_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk1("rstpend_req0_ready", req0_ready, 1'b0);
        tick();
        reset = 1'b0;
        set1(1'b1, 32'd3, 32'd3, ALU_ADD);
        resp1_ready = 1'b1;
        @(negedge clk);
        chk1("rstpend_v0", resp0_valid, 1'b0);
        chk1("rstpend_v1", resp1_valid, 1'b0);
        chk("rstpend_r0", resp0_result, 32'd0);
        chk("rstpend_r1", resp1_result, 32'd0);
        chk1("rstpend_ptr", req0_ready, 1'b1);
        tick();
        set0(1'b0, 0, 0, 3'b000);
        set1(1'b0, 0, 0, 3'b000);
        repeat (2) tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // undefined op code
        set0(1'b1, 32'hffff_ffff, 32'd1, 3'b011);
        @(negedge clk);
        chk1("undef_ready", req0_ready, 1'b1);
        tick();
        set0(1'b0, 0, 0, 3'b000);
        @(negedge clk);
        chk("undef_result", resp0_result, 32'd0);
        chk1("undef_zero", resp0_zero, 1'b1);
        tick();
        resp0_ready = 1'b1;
        tick();

        // random traffic; a stalled request is held stable
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (!(req0_valid && !m_gnt[0])) begin
                set0($urandom_range(0, 1) == 1, $urandom, $urandom,
                     3'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) req0_b = req0_a;
            end
            if (!(req1_valid && !m_gnt[1])) begin
                set1($urandom_range(0, 1) == 1, $urandom, $urandom,
                     3'($urandom_range(0, 7)));
                if ($urandom_range(0, 3) == 0) req1_b = req1_a;
            end
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        reset = 1'b0;
        set0(1'b0, 0, 0, 3'b000);
        set1(1'b0, 0, 0, 3'b000);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (3) tick();
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
